// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scan sequencer for an N_CH:1 bit mux, word out on valid/ready
// Optional MUX_SCAN_CONT_EN: rescan back-to-back after each accepted word.
module mux_scan_ctrl #(
  parameter  int SEL_W  = 3,
  parameter  int SETTLE = 1,
  localparam int N_CH   = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [SEL_W-1:0] sel,
  input  logic             y_in,
  output logic             busy,
  output logic [N_CH-1:0]  data_out,
  output logic             data_valid,
  input  logic             data_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(N_CH - 1);
  // With no settle time every channel slot is a single SAMPLE cycle.
  localparam state_t           SLOT_ST   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel,   w_sel_nxt;
  logic [3:0]       r_cnt,   w_cnt_nxt;
  logic [N_CH-1:0]  r_cap,   w_cap_nxt;
  logic [N_CH-1:0]  r_data,  w_data_nxt;
  logic             r_valid, w_valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        if (start) begin
          w_state_nxt = SLOT_ST;
          w_cnt_nxt   = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_cap_nxt[r_sel] = y_in;
        if (r_sel == LAST_SEL) begin
          w_data_nxt  = w_cap_nxt;
          w_valid_nxt = 1'b1;
          w_sel_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_sel_nxt   = r_sel + 1'b1;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = SLOT_ST;
        end
      end
      S_DONE: begin
        if (data_ready) begin
          w_valid_nxt = 1'b0;
`ifdef MUX_SCAN_CONT_EN
          w_sel_nxt   = '0;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = SLOT_ST;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sel        = r_sel;
  assign busy       = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign data_out   = r_data;
  assign data_valid = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
// Covers SETTLE=1 and SETTLE=0 instances; continuous-mode steps under MUX_SCAN_CONT_EN.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, ready = 1'b0;
  logic [7:0] ip = 8'h00;
  logic [2:0] sel;
  logic       y_in, busy, valid;
  logic [7:0] data;

  logic       start0 = 1'b0, ready0 = 1'b0;
  logic [7:0] ip0 = 8'h00;
  logic [2:0] sel0;
  logic       y0, busy0, valid0;
  logic [7:0] data0;

  int checks = 0;
  int errors = 0;
  int n_words;

  always #5 clk = ~clk;

  assign y_in = ip[sel];
  assign y0   = ip0[sel0];

  mux_scan_ctrl #(.SEL_W(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .y_in(y_in), .busy(busy),
    .data_out(data), .data_valid(valid), .data_ready(ready)
  );

  mux_scan_ctrl #(.SEL_W(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sel(sel0), .y_in(y0), .busy(busy0),
    .data_out(data0), .data_valid(valid0), .data_ready(ready0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick;
    check("rst_sel", 32'(sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    rst_n = 1'b1;

    // 1: ip=AA, SETTLE=1, each channel held two cycles
    ip = 8'hAA;
    ready = 1'b1;
    pulse_start;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_sel_%0d", k), 32'(sel), 32'(k / 2));
      check($sformatf("t1_busy_%0d", k), 32'(busy), 1);
      check($sformatf("t1_valid_%0d", k), 32'(valid), 0);
      tick;
    end
    check("t1_valid", 32'(valid), 1);
    check("t1_data", 32'(data), 32'h AA);
    check("t1_busy_done", 32'(busy), 0);
    check("t1_sel_done", 32'(sel), 0);
    tick;
    check("t1_valid_drop", 32'(valid), 0);
    check("t1_busy_after", 32'(busy), 32'(CONT));

    // 2: consumer stalls for 5 cycles
    do_reset;
    ip = 8'h3C;
    ready = 1'b0;
    pulse_start;
    repeat (16) tick;
    check("t2_valid", 32'(valid), 1);
    check("t2_data", 32'(data), 32'h3C);
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("t2_hold_valid_%0d", i), 32'(valid), 1);
      check($sformatf("t2_hold_data_%0d", i), 32'(data), 32'h3C);
    end
    ready = 1'b1;
    tick;
    check("t2_accept_valid", 32'(valid), 0);
    check("t2_accept_busy", 32'(busy), 32'(CONT));
    ready = 1'b0;

    // 3: start re-pulsed mid-scan is ignored
    do_reset;
    ip = 8'hF0;
    ready = 1'b1;
    pulse_start;
    for (int k = 1; k < 16; k++) begin
      start = (k == 3) || (k == 9);
      tick;
      check($sformatf("t3_busy_%0d", k), 32'(busy), 1);
    end
    start = 1'b0;
    tick;
    check("t3_valid", 32'(valid), 1);
    check("t3_data", 32'(data), 32'hF0);
    tick;
    check("t3_valid_drop", 32'(valid), 0);
`ifndef MUX_SCAN_CONT_EN
    n_words = 0;
    repeat (20) begin
      tick;
      if (valid) n_words++;
    end
    check("t3_no_extra_word", 32'(n_words), 0);
`endif
    ready = 1'b0;

    // 4: asynchronous reset in the channel-4 slot
    do_reset;
    ip = 8'h81;
    pulse_start;
    repeat (16) tick;
    check("t4_first_data", 32'(data), 32'h81);
    ready = 1'b1;
`ifdef MUX_SCAN_CONT_EN
    tick;
`else
    tick;
    pulse_start;
`endif
    ready = 1'b0;
    repeat (8) tick;
    check("t4_sel_mid", 32'(sel), 4);
    check("t4_busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_sel", 32'(sel), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_valid", 32'(valid), 0);
    check("t4_rst_data", 32'(data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_start;
    repeat (16) tick;
    check("t4_valid", 32'(valid), 1);
    check("t4_data", 32'(data), 32'h81);
    ready = 1'b1;
    tick;
    check("t4_accept", 32'(valid), 0);
    ready = 1'b0;

    // 5: SETTLE=0 instance, one cycle per channel
    do_reset;
    ip0 = 8'h5A;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t5_sel_%0d", k), 32'(sel0), 32'(k));
      check($sformatf("t5_busy_%0d", k), 32'(busy0), 1);
      check($sformatf("t5_valid_%0d", k), 32'(valid0), 0);
      tick;
    end
    check("t5_valid", 32'(valid0), 1);
    check("t5_data", 32'(data0), 32'h5A);
    check("t5_busy_done", 32'(busy0), 0);
    tick;
    check("t5_valid_drop", 32'(valid0), 0);
    ready0 = 1'b0;

`ifdef MUX_SCAN_CONT_EN
    // 6: back-to-back scans, pulses 17 cycles apart
    do_reset;
    ip = 8'h11;
    ready = 1'b1;
    pulse_start;
    repeat (15) tick;
    check("t6_valid_early", 32'(valid), 0);
    tick;
    check("t6_valid1", 32'(valid), 1);
    check("t6_data1", 32'(data), 32'h11);
    ip = 8'h22;
    tick;
    check("t6_busy_restart", 32'(busy), 1);
    repeat (15) tick;
    check("t6_valid_gap", 32'(valid), 0);
    tick;
    check("t6_valid2", 32'(valid), 1);
    check("t6_data2", 32'(data), 32'h22);
    ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
